// File: rtl/addsub_multiword_sequencer.sv
// Drives an external combinational adder/subtractor word by word, LS word first,
// chaining carry/borrow between words of an N-word extended-precision operation.
module addsub_multiword_sequencer #(
  parameter int unsigned WORD_WIDTH  = 36,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_sub,
  input  logic                   cmd_carry_in,
  input  logic [COUNT_WIDTH-1:0] cmd_count,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [WORD_WIDTH-1:0]  op_a,
  input  logic [WORD_WIDTH-1:0]  op_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WORD_WIDTH-1:0]  res_sum,
  output logic                   res_last,
  output logic                   done,
  output logic                   final_carry,
  output logic                   addsub_sub_add,
  output logic                   addsub_carry_in,
  output logic [WORD_WIDTH-1:0]  addsub_a,
  output logic [WORD_WIDTH-1:0]  addsub_b,
  input  logic [WORD_WIDTH-1:0]  addsub_sum,
  input  logic                   addsub_carry_out
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                 state, state_next;
  logic                   sub_q;
  logic                   carry_q;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   cmd_fire;
  logic                   op_fire;
  logic                   last_word;

  assign addsub_a        = op_a;
  assign addsub_b        = op_b;
  assign addsub_sub_add  = sub_q;
  assign addsub_carry_in = carry_q;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign op_fire   = op_valid & op_ready;
  assign last_word = (remaining == COUNT_WIDTH'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    op_ready   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_fire && (cmd_count != '0)) state_next = RUN;
      end
      RUN: begin
        // A held result with a stalled sink back-pressures the operand stream.
        op_ready = ~res_valid | res_ready;
        if (op_fire && last_word) state_next = FLUSH;
      end
      FLUSH: begin
        if (res_valid && res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      remaining   <= '0;
      res_valid   <= 1'b0;
      res_last    <= 1'b0;
      res_sum     <= '0;
      done        <= 1'b0;
      final_carry <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            sub_q     <= cmd_sub;
            carry_q   <= cmd_carry_in;
            remaining <= cmd_count;
            // A zero-length operation completes at once, passing the carry through.
            if (cmd_count == '0) begin
              done        <= 1'b1;
              final_carry <= cmd_carry_in;
            end else begin
              final_carry <= 1'b0;
            end
          end
        end
        RUN: begin
          if (op_fire) begin
            res_sum   <= addsub_sum;
            carry_q   <= addsub_carry_out;
            res_valid <= 1'b1;
            remaining <= remaining - COUNT_WIDTH'(1);
            res_last  <= last_word;
            if (last_word) final_carry <= addsub_carry_out;
          end else if (res_ready) begin
            res_valid <= 1'b0;
          end
        end
        FLUSH: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/addsub_multiword_sequencer.md
Name: addsub_multiword_sequencer

Overview:
Sequences a single-word ripple-carry adder/subtractor over an N-word extended-precision operation. Words are processed least-significant first, and each word's carry/borrow out is fed back as the next word's carry_in. The block sits between a command/operand source (I/O port or DMA-style streamer) and a result sink, and drives an external adder/subtractor instance through dedicated ports. The adder itself is purely combinational and lives outside the block.

Parameters:
WORD_WIDTH, 36, width of each operand/result word and of the adder datapath.
COUNT_WIDTH, 8, width of the word-count field; maximum operation length is 2^COUNT_WIDTH-1 words.

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_sub  in  1  1 = A-B, 0 = A+B
cmd_carry_in  in  1  initial carry/borrow into word 0
cmd_count  in  COUNT_WIDTH  number of words in the operation
op_valid  in  1  operand pair offered
op_ready  out  1  operand pair accepted when op_valid & op_ready
op_a  in  WORD_WIDTH  A word
op_b  in  WORD_WIDTH  B word
res_valid  out  1  result word held
res_ready  in  1  sink accepts result
res_sum  out  WORD_WIDTH  result word
res_last  out  1  marks the final word of the operation
done  out  1  one-cycle pulse: operation complete
final_carry  out  1  carry/borrow out of the most-significant word; held until the next command is accepted
addsub_sub_add  out  1  to adder: the latched cmd_sub
addsub_carry_in  out  1  to adder: the running carry register
addsub_a  out  WORD_WIDTH  to adder: op_a passthrough
addsub_b  out  WORD_WIDTH  to adder: op_b passthrough
addsub_sum  in  WORD_WIDTH  from adder
addsub_carry_out  in  1  from adder (1 = carry on add, borrow on sub)

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; res_valid, res_last, done, final_carry, the running carry, the latched sub bit and the remaining count all 0; res_sum=0. Reset mid-operation abandons the operation; no done pulse is issued.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - cmd_ready=1, op_ready=0.
  - On cmd accept: latch cmd_sub, load carry=cmd_carry_in, load remaining=cmd_count, clear final_carry.
  - Next state is RUN if cmd_count≠0. If cmd_count=0: no words are consumed, done pulses the next cycle, final_carry=cmd_carry_in, and the block stays in IDLE.
- RUN:
  - cmd_ready=0.
  - op_ready = ~res_valid | res_ready, so a full output register with a stalled sink back-pressures the operand stream.
  - On op accept: res_sum<=addsub_sum, carry<=addsub_carry_out, res_valid<=1, remaining<=remaining-1, res_last<=(remaining==1).
  - When the last word is accepted: final_carry<=addsub_carry_out, then go to FLUSH.
  - Latency is 1 cycle from operand accept to res_valid. Throughput is 1 word/cycle when res_ready=1.
- FLUSH:
  - op_ready=0, cmd_ready=0.
  - When res_valid & res_ready: res_valid<=0, res_last<=0, done pulses for exactly 1 cycle in the following cycle, state<=IDLE.
- Result handshake in RUN: if res_ready=1 and no operand is accepted that cycle, res_valid<=0.
- Adder outputs (addsub_a, addsub_b, addsub_sub_add, addsub_carry_in) are driven combinationally. The adder is combinational, so its result is sampled in the same cycle as the operand accept.
- The running carry is unsigned 1-bit. Word arithmetic is modulo 2^WORD_WIDTH; signedness is interpreted only by the consumer of the MS word.
- A new command is accepted no earlier than the cycle in which done is high. Back-to-back commands therefore have 1 idle cycle between them.
- op_valid in IDLE/FLUSH is ignored (op_ready=0); operand data is never dropped.

Test Plan:
- WORD_WIDTH=8, add, count=2, A={0x01,0xFF} (MS first), B={0x00,0x01}, carry_in=0 -> results 0x00 (last=0), then 0x02 (last=1); final_carry=0; done pulses once.
- Sub, count=3, A=0x000000, B=0x000001 -> results 0xFF,0xFF,0xFF; final_carry=1 (borrow).
- Add, count=1, A=0xFF, B=0x00, cmd_carry_in=1 -> result 0x00, final_carry=1, res_last=1 on the single word.
- Add, count=4, with res_ready held low for 3 cycles after the first result -> op_ready=0 during the stall; results are correct and in order; no operand is lost or duplicated.
- count=0, cmd_carry_in=1 -> no op_ready assertion, done the next cycle, final_carry=1.
- reset_n low mid-RUN after 2 of 4 words -> all outputs clear immediately and asynchronously, no done pulse; a new count=1 add then completes correctly with carry starting from cmd_carry_in.
